// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if: request/grant bundle between requesters (master) and clk_gate_ctrl (slave)
// Ports carried:
//   req         requester -> ctrl  per-requester level clock request
//   force_on    requester -> ctrl  debug override, a request that never gets an ack
//   evt_clr     requester -> ctrl  synchronous clear of wake_events
//   clk_en      ctrl -> requester  registered enable for the clock-gating cell
//   ack         ctrl -> requester  per-requester grant, clock enabled and stable
//   state_o     ctrl -> requester  0 OFF, 1 WAKE, 2 ON, 3 IDLE
//   wake_events ctrl -> requester  saturating count of OFF->WAKE transitions
interface clk_gate_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int EVT_W = 16
);
  logic [N_REQ-1:0] req;
  logic force_on;
  logic evt_clr;
  logic clk_en;
  logic [N_REQ-1:0] ack;
  logic [1:0] state_o;
  logic [EVT_W-1:0] wake_events;
  modport master (output req, force_on, evt_clr, input clk_en, ack, state_o, wake_events);
  modport slave (input req, force_on, evt_clr, output clk_en, ack, state_o, wake_events);
endinterface

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: wakes a shared gated clock on demand, acks once stable, gates it after an idle hysteresis
// Ports:
//   clk_in  free-running ungated clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     clk_gate_ctrl_if slave: req/force_on/evt_clr in, clk_en/ack/state_o/wake_events out
module clk_gate_ctrl #(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 8,
  parameter int EVT_W    = 16
) (
  input logic clk_in,
  input logic rst_n,
  clk_gate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, IDLE = 2'd3} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic clk_en_q;
  logic any_req, cnt_zero;
  assign any_req = |bus.req | bus.force_on;
  assign cnt_zero = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      OFF: begin
        state_d = any_req ? WAKE : OFF;
        cnt_d = any_req ? CNT_W'(WAKE_CYC - 1) : cnt_q;
      end
      WAKE: begin
        state_d = cnt_zero ? ON : WAKE;
        cnt_d = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
      end
      ON: begin
        state_d = any_req ? ON : IDLE;
        cnt_d = any_req ? cnt_q : CNT_W'(IDLE_CYC - 1);
      end
      IDLE: begin
        // a request landing on the expiry edge wins: straight back to ON, no re-wake
        state_d = any_req ? ON : cnt_zero ? OFF : IDLE;
        cnt_d = (any_req || cnt_zero) ? cnt_q : cnt_q - CNT_W'(1);
      end
    endcase
    // clear beats a coincident increment
    evt_d = bus.evt_clr ? '0 :
            (state_q == OFF && any_req && !(&evt_q)) ? evt_q + EVT_W'(1) : evt_q;
    ack_d = state_d == ON ? bus.req : '0;
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q <= '0;
      evt_q <= '0;
      ack_q <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      evt_q <= evt_d;
      ack_q <= ack_d;
      clk_en_q <= state_d != OFF;
    end
  end
  assign bus.clk_en = clk_en_q;
  assign bus.ack = ack_q;
  assign bus.state_o = state_q;
  assign bus.wake_events = evt_q;
  ack_needs_on: assert property (@(posedge clk_in) disable iff (!rst_n) |ack_q |-> state_q == ON);
  en_tracks_state: assert property (@(posedge clk_in) disable iff (!rst_n) clk_en_q == (state_q != OFF));
endmodule
